perf_counter_unit: RTL and testbench

//   Run-statistics counters for the pipelined CPU. Counts total cycles, unconditional

---
 rtl/perf_counter_unit.sv | 157 +++++++++++++++
 tb/tb_perf_counter_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_unit.sv
// -----------------------------------------------------------------------------
// perf_counter_unit
//   Run-statistics counters for the pipelined CPU. While the CPU runs, this
//   block counts total cycles, unconditional jumps, taken conditional branches
//   and inserted bubbles. All counts freeze once the CPU halts. The outputs feed
//   the seven-segment display stage as plain binary values; that stage does its
//   own BCD conversion.
//
//   Build option (compile-time macro):
//     PERF_SATURATE_EN  defined   : a counter at all-ones holds at all-ones
//                       undefined : a counter at all-ones wraps to 0
//     Both builds set the counter's sticky ovf bit and use the same port list.
//
// Ports
//   clk                 in   system clock
//   rst                 in   asynchronous, active-high reset
//   cpu_go              in   level, enables counting (IDLE -> RUN)
//   halt                in   1-cycle halt pulse (RUN -> HALT, cycle counted)
//   clear               in   synchronous clear of counts/ovf, returns to IDLE
//   uncondi_branch      in   unconditional jump retired this cycle
//   condi_branch        in   conditional branch taken this cycle
//   bubble              in   bubble inserted this cycle
//   total_cycles        out  cycles spent in RUN
//   uncondi_branch_num  out  unconditional jump count
//   condi_branch_num    out  taken conditional branch count
//   bubble_num          out  bubble count
//   running             out  FSM is in RUN
//   halted              out  FSM is in HALT
//   ovf                 out  sticky overflow {bubble, condi, uncondi, total}
// -----------------------------------------------------------------------------
module perf_counter_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_go,
  input  logic             halt,
  input  logic             clear,
  input  logic             uncondi_branch,
  input  logic             condi_branch,
  input  logic             bubble,
  output logic [CNT_W-1:0] total_cycles,
  output logic [CNT_W-1:0] uncondi_branch_num,
  output logic [CNT_W-1:0] condi_branch_num,
  output logic [CNT_W-1:0] bubble_num,
  output logic             running,
  output logic             halted,
  output logic [3:0]       ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state_q;
  logic   running_q;
  logic   halted_q;

  // Counter index: 0 = total, 1 = uncondi, 2 = condi, 3 = bubble
  // (same bit order as ovf).
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0][CNT_W-1:0] cnt_d;
  logic [3:0]            ovf_q;
  logic [3:0]            ovf_d;
  logic                  count_en;
  logic [3:0]            inc;

  // FSM with registered Moore flags. Clear overrides every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else if (clear) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_go) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (halt) begin
            state_q   <= S_HALT;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
          end else if (!cpu_go) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end
        end
        S_HALT: begin
          // Frozen until clear or rst; halt and cpu_go are ignored here.
          state_q <= S_HALT;
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  // Every cycle spent in RUN is counted, including the halt cycle and a cycle
  // where cpu_go drops. Events in the clear cycle are discarded.
  assign count_en = (state_q == S_RUN) && !clear;
  assign inc      = {bubble, condi_branch, uncondi_branch, 1'b1} & {4{count_en}};

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < 4; i++) begin
      if (inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
`ifdef PERF_SATURATE_EN
          cnt_d[i] = cnt_q[i];
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    if (clear) begin
      cnt_d = '0;
      ovf_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign total_cycles       = cnt_q[0];
  assign uncondi_branch_num = cnt_q[1];
  assign condi_branch_num   = cnt_q[2];
  assign bubble_num         = cnt_q[3];
  assign ovf                = ovf_q;
  assign running            = running_q;
  assign halted             = halted_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
module tb_perf_counter_unit;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (CNT_W = 32)
  logic        cpu_go, halt, clear, ub, cb, bub;
  logic [31:0] total_cycles, uncondi_num, condi_num, bubble_num;
  logic        running, halted;
  logic [3:0]  ovf;

  perf_counter_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_go(cpu_go), .halt(halt), .clear(clear),
    .uncondi_branch(ub), .condi_branch(cb), .bubble(bub),
    .total_cycles(total_cycles), .uncondi_branch_num(uncondi_num),
    .condi_branch_num(condi_num), .bubble_num(bubble_num),
    .running(running), .halted(halted), .ovf(ovf)
  );

  // narrow DUT for overflow behaviour (CNT_W = 4)
  logic       s_cpu_go;
  logic [3:0] s_total, s_ub_num, s_cb_num, s_bub_num;
  logic       s_running, s_halted;
  logic [3:0] s_ovf;

  perf_counter_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .cpu_go(s_cpu_go), .halt(1'b0), .clear(1'b0),
    .uncondi_branch(1'b0), .condi_branch(1'b0), .bubble(1'b0),
    .total_cycles(s_total), .uncondi_branch_num(s_ub_num),
    .condi_branch_num(s_cb_num), .bubble_num(s_bub_num),
    .running(s_running), .halted(s_halted), .ovf(s_ovf)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed=%0h but scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1 time unit after posedge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic u, input logic c, input logic b);
    ub = u; cb = c; bub = b;
  endtask

  initial begin
    cpu_go = 0; halt = 0; clear = 0; s_cpu_go = 0;
    set_ev(0, 0, 0);

    // ---- reset state
    step(3);
    rst = 0;
    push(0); push(0); push(0); push(0); push(0); push(0); push(0);
    chk("rst_total", total_cycles);
    chk("rst_uncondi", uncondi_num);
    chk("rst_condi", condi_num);
    chk("rst_bubble", bubble_num);
    chk("rst_running", {31'd0, running});
    chk("rst_halted", {31'd0, halted});
    chk("rst_ovf", {28'd0, ovf});

    // ---- events in IDLE are dropped
    for (int i = 0; i < 6; i++) begin
      set_ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      step(1);
    end
    set_ev(0, 0, 0);
    push(0); push(0); push(0); push(0);
    chk("idle_total", total_cycles);
    chk("idle_uncondi", uncondi_num);
    chk("idle_condi", condi_num);
    chk("idle_bubble", bubble_num);

    // ---- cpu_go then halt: 9 RUN cycles plus the counted halt cycle = 10
    cpu_go = 1;
    push(1); push(0);
    step(1);
    chk("go_running", {31'd0, running});
    chk("go_total", total_cycles);
    step(9);
    halt = 1;
    push(10); push(1); push(0);
    step(1);
    halt = 0;
    chk("halt_total", total_cycles);
    chk("halt_halted", {31'd0, halted});
    chk("halt_running", {31'd0, running});

    // ---- HALT freezes everything, inputs ignored
    for (int i = 0; i < 20; i++) begin
      set_ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      halt   = 1'($urandom_range(0, 1));
      cpu_go = 1'($urandom_range(0, 1));
      step(1);
    end
    set_ev(0, 0, 0); halt = 0; cpu_go = 1;
    push(10); push(0); push(0); push(0); push(1);
    chk("frz_total", total_cycles);
    chk("frz_uncondi", uncondi_num);
    chk("frz_condi", condi_num);
    chk("frz_bubble", bubble_num);
    chk("frz_halted", {31'd0, halted});

    // ---- clear from HALT, cpu_go still 1 -> RUN the cycle after
    clear = 1;
    step(1);
    clear = 0;
    push(0); push(0); push(0);
    chk("clr_h_total", total_cycles);
    chk("clr_h_halted", {31'd0, halted});
    chk("clr_h_running", {31'd0, running});
    push(1);
    step(1);
    chk("clr_h_rerun", {31'd0, running});

    // ---- all three events high 5 cycles, checked edge for edge
    set_ev(1, 1, 1);
    for (int k = 1; k <= 5; k++) begin
      push(32'(k)); push(32'(k)); push(32'(k));
      step(1);
      chk("ev_uncondi", uncondi_num);
      chk("ev_condi", condi_num);
      chk("ev_bubble", bubble_num);
    end
    set_ev(0, 0, 0);
    push(5);
    chk("ev_total", total_cycles);

    // ---- clear in RUN with bubble: bubble discarded, IDLE, then RUN again
    bub = 1; clear = 1;
    push(0); push(0); push(0); push(0);
    step(1);
    bub = 0; clear = 0;
    chk("clr_r_total", total_cycles);
    chk("clr_r_bubble", bubble_num);
    chk("clr_r_uncondi", uncondi_num);
    chk("clr_r_running", {31'd0, running});
    push(1); push(0);
    step(1);
    chk("clr_r_rerun", {31'd0, running});
    chk("clr_r_total2", total_cycles);
    step(3);
    // cpu_go drop: that RUN cycle is counted, then counts retained in IDLE
    cpu_go = 0;
    step(1);
    push(4); push(0);
    chk("drop_total", total_cycles);
    chk("drop_running", {31'd0, running});
    bub = 1;
    step(3);
    bub = 0;
    push(4); push(0);
    chk("idle2_total", total_cycles);
    chk("idle2_bubble", bubble_num);

    // ---- async reset mid-RUN
    cpu_go = 1;
    step(1);
    bub = 1;
    step(3);
    bub = 0;
    push(3);
    chk("pre_rst_bubble", bubble_num);
    #2 rst = 1;
    #1;
    push(0); push(0); push(0);
    chk("arst_total", total_cycles);
    chk("arst_bubble", bubble_num);
    chk("arst_running", {31'd0, running});
    #1 rst = 0;
    step(1);
    push(1); push(0);
    chk("arst_rerun", {31'd0, running});
    chk("arst_total0", total_cycles);
    step(4);
    push(4);
    chk("arst_total4", total_cycles);

    // ---- 4-bit overflow, 17 RUN cycles
    s_cpu_go = 1;
    step(1);
    step(15);
    push(32'hF); push(0);
    chk("s_total15", {28'd0, s_total});
    chk("s_ovf15", {28'd0, s_ovf});
    step(2);
`ifdef PERF_SATURATE_EN
    push(32'hF);
`else
    push(32'h1);
`endif
    push(32'h1);
    chk("s_total17", {28'd0, s_total});
    chk("s_ovf17", {28'd0, s_ovf});

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_drain: observed=%0d leftover entries expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
